// File: rtl/ej32_fetch_if.sv
// Fetch-unit bundle: redirect input, byte-read memory bus and prefetch-queue
// head toward the decoder. "master" is the fetch unit, "slave" the surrounding
// core (branch unit, memory and decoder together).
interface ej32_fetch_if #(
  parameter int ASZ = 17,
  parameter int CSZ = 3
);
  logic [ASZ-1:0] br_p_i;
  logic           br_psel_i;
  logic [ASZ-1:0] mem_a_o;
  logic           mem_req_o;
  logic [7:0]     mem_d_i;
  logic [7:0]     q_d_o;
  logic [ASZ-1:0] q_p_o;
  logic           q_vld_o;
  logic           q_pop_i;
  logic [CSZ-1:0] cnt_o;

  modport master (
    input  br_p_i, br_psel_i, mem_d_i, q_pop_i,
    output mem_a_o, mem_req_o, q_d_o, q_p_o, q_vld_o, cnt_o
  );

  modport slave (
    output br_p_i, br_psel_i, mem_d_i, q_pop_i,
    input  mem_a_o, mem_req_o, q_d_o, q_p_o, q_vld_o, cnt_o
  );
endinterface

// File: rtl/ej32_fetch.sv
// eJ32 instruction-byte fetch unit. Owns the fetch pointer, issues one byte
// read per cycle against a fixed 1-cycle memory, and buffers {byte, addr}
// pairs in a small circular prefetch queue drained by the decoder. A redirect
// strobe flushes everything and restarts fetch at the branch target.
module ej32_fetch #(
  parameter int ASZ   = 17,
  parameter int DEPTH = 4,
  parameter int CSZ   = 3
) (
  input  logic         clk,
  input  logic         rst,
  ej32_fetch_if.master bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = CSZ + 1;

  logic [ASZ-1:0] fa;        // next address to fetch
  logic [ASZ-1:0] req_a;     // address of the request whose data arrives now
  logic           inflight;  // a request was issued last cycle
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;
  logic [CSZ-1:0] cnt;

  logic [7:0]     d_mem [DEPTH];
  logic [ASZ-1:0] p_mem [DEPTH];

  logic [7:0]     hold_d;    // last head byte shown, kept while empty
  logic [ASZ-1:0] hold_p;

  logic           redirect;
  logic           issue;
  logic           push;
  logic           pop;
  logic           vld;
  logic [CW-1:0]  credit;
  logic [7:0]     head_d;
  logic [ASZ-1:0] head_p;

  // Issue/push/pop decisions and head selection for this cycle.
  // NOTE: every signal here is assigned on every path, so no latch can form.
  always_comb begin
    redirect = bus.br_psel_i;
    credit   = CW'(cnt) + CW'(inflight);
    // A redirect suppresses issue; the credit rule keeps the queue from overflowing.
    issue    = !rst && !redirect && (credit < CW'(DEPTH));
    // Data landing in the redirect cycle belongs to the old stream and is dropped.
    push     = inflight && !redirect;
    pop      = bus.q_pop_i && (cnt != '0) && !redirect;
    vld      = (cnt != '0);
    head_d   = vld ? d_mem[rd_ptr] : hold_d;
    head_p   = vld ? p_mem[rd_ptr] : hold_p;
  end

  assign bus.mem_req_o = issue;
  assign bus.mem_a_o   = fa;
  assign bus.q_vld_o   = vld;
  assign bus.q_d_o     = head_d;
  assign bus.q_p_o     = head_p;
  assign bus.cnt_o     = cnt;

  // Fetch pointer, request tracking, queue pointers and occupancy.
  // NOTE: state registers use non-blocking assignments so every block sees
  // the same pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fa       <= '0;
      req_a    <= '0;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      cnt      <= '0;
    end else if (redirect) begin
      fa       <= bus.br_p_i;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      cnt      <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        fa    <= fa + ASZ'(1);
        req_a <= fa;
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CSZ'(1);
        2'b01:   cnt <= cnt - CSZ'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Queue storage: write the returning byte and its address at the tail.
  // NOTE: storage is not reset; an entry is only read while cnt says it holds
  // a pushed value, and the empty-queue outputs come from the hold registers.
  always_ff @(posedge clk) begin
    if (push) begin
      d_mem[wr_ptr] <= bus.mem_d_i;
      p_mem[wr_ptr] <= req_a;
    end
  end

  // Remember the displayed head so the outputs stay put while the queue is empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_d <= '0;
      hold_p <= '0;
    end else begin
      hold_d <= head_d;
      hold_p <= head_p;
    end
  end

endmodule

// File: tb/tb_ej32_fetch.sv
// Bench for ej32_fetch: directed timing scenarios plus a randomized run
// checked against an in-order address-stream model.
module tb_ej32_fetch;

  localparam int ASZ   = 17;
  localparam int DEPTH = 4;
  localparam int CSZ   = 3;

  logic clk;
  logic rst;
  int   passed = 0;
  int   total  = 0;

  ej32_fetch_if #(.ASZ(ASZ), .CSZ(CSZ)) bus ();

  ej32_fetch #(.ASZ(ASZ), .DEPTH(DEPTH), .CSZ(CSZ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory contents: mem[a] = a+0x10 for low addresses, mixed with a[15:8] above.
  function automatic logic [7:0] mdat(input logic [ASZ-1:0] a);
    return (a[7:0] + 8'h10) ^ a[15:8];
  endfunction

  // 1-cycle-latency memory: data for a request seen at an edge appears after it.
  always @(posedge clk) bus.mem_d_i <= bus.mem_req_o ? mdat(bus.mem_a_o) : 8'hEE;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.br_psel_i = 1'b0;
    bus.br_p_i    = '0;
    bus.q_pop_i   = 1'b0;
    repeat (2) @(posedge clk);
    sample();
    total++; if (bus.mem_req_o !== 1'b0) $display("FAIL reset_req got=%0h exp=0", bus.mem_req_o); else passed++;
    total++; if (bus.mem_a_o !== '0) $display("FAIL reset_a got=%0h exp=0", bus.mem_a_o); else passed++;
    total++; if (bus.q_vld_o !== 1'b0) $display("FAIL reset_vld got=%0h exp=0", bus.q_vld_o); else passed++;
    total++; if (bus.q_d_o !== 8'h00) $display("FAIL reset_qd got=%0h exp=0", bus.q_d_o); else passed++;
    total++; if (bus.q_p_o !== '0) $display("FAIL reset_qp got=%0h exp=0", bus.q_p_o); else passed++;
    total++; if (bus.cnt_o !== '0) $display("FAIL reset_cnt got=%0h exp=0", bus.cnt_o); else passed++;
  endtask

  task automatic test_fill();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      sample();
      total++; if (bus.mem_req_o !== 1'b1) $display("FAIL fill_req[%0d] got=%0h exp=1", i, bus.mem_req_o); else passed++;
      total++; if (bus.mem_a_o !== ASZ'(i)) $display("FAIL fill_a[%0d] got=%0h exp=%0h", i, bus.mem_a_o, i); else passed++;
    end
    tick(); sample();
    total++; if (bus.mem_req_o !== 1'b0) $display("FAIL fill_credit got=%0h exp=0", bus.mem_req_o); else passed++;
    tick(); sample();
    total++; if (bus.cnt_o !== CSZ'(DEPTH)) $display("FAIL fill_cnt got=%0h exp=%0h", bus.cnt_o, DEPTH); else passed++;
    total++; if (bus.q_vld_o !== 1'b1) $display("FAIL fill_vld got=%0h exp=1", bus.q_vld_o); else passed++;
    total++; if (bus.q_p_o !== '0) $display("FAIL fill_qp got=%0h exp=0", bus.q_p_o); else passed++;
    total++; if (bus.q_d_o !== 8'h10) $display("FAIL fill_qd got=%0h exp=10", bus.q_d_o); else passed++;
  endtask

  task automatic test_stream();
    tick();
    bus.q_pop_i = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      sample();
      total++; if (bus.q_vld_o !== 1'b1) $display("FAIL stream_vld[%0d] got=%0h exp=1", k, bus.q_vld_o); else passed++;
      total++; if (bus.q_p_o !== ASZ'(k)) $display("FAIL stream_qp[%0d] got=%0h exp=%0h", k, bus.q_p_o, k); else passed++;
      total++; if (bus.q_d_o !== mdat(ASZ'(k))) $display("FAIL stream_qd[%0d] got=%0h exp=%0h", k, bus.q_d_o, mdat(ASZ'(k))); else passed++;
      tick();
    end
  endtask

  // Redirect while a request is in flight and the consumer is popping.
  task automatic test_redirect();
    bus.br_psel_i = 1'b1;
    bus.br_p_i    = ASZ'(17'h00100);
    sample();
    total++; if (bus.mem_req_o !== 1'b0) $display("FAIL redir_n_req got=%0h exp=0", bus.mem_req_o); else passed++;
    tick();
    bus.br_psel_i = 1'b0;
    bus.q_pop_i   = 1'b0;
    sample();
    total++; if (bus.cnt_o !== '0) $display("FAIL redir_n1_cnt got=%0h exp=0", bus.cnt_o); else passed++;
    total++; if (bus.q_vld_o !== 1'b0) $display("FAIL redir_n1_vld got=%0h exp=0", bus.q_vld_o); else passed++;
    total++; if (bus.mem_req_o !== 1'b1) $display("FAIL redir_n1_req got=%0h exp=1", bus.mem_req_o); else passed++;
    total++; if (bus.mem_a_o !== ASZ'(17'h00100)) $display("FAIL redir_n1_a got=%0h exp=100", bus.mem_a_o); else passed++;
    tick(); sample();
    total++; if (bus.q_vld_o !== 1'b0) $display("FAIL redir_n2_vld got=%0h exp=0", bus.q_vld_o); else passed++;
    tick(); sample();
    total++; if (bus.q_vld_o !== 1'b1) $display("FAIL redir_n3_vld got=%0h exp=1", bus.q_vld_o); else passed++;
    total++; if (bus.q_p_o !== ASZ'(17'h00100)) $display("FAIL redir_n3_qp got=%0h exp=100", bus.q_p_o); else passed++;
    total++; if (bus.q_d_o !== mdat(ASZ'(17'h00100))) $display("FAIL redir_n3_qd got=%0h exp=%0h", bus.q_d_o, mdat(ASZ'(17'h00100))); else passed++;
  endtask

  task automatic test_wrap();
    logic [ASZ-1:0] e;
    tick();
    bus.br_psel_i = 1'b1;
    bus.br_p_i    = ASZ'(17'h1FFFE);
    sample();
    tick();
    bus.br_psel_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      e = ASZ'(17'h1FFFE) + ASZ'(i);
      sample();
      total++; if (bus.mem_req_o !== 1'b1) $display("FAIL wrap_req[%0d] got=%0h exp=1", i, bus.mem_req_o); else passed++;
      total++; if (bus.mem_a_o !== e) $display("FAIL wrap_a[%0d] got=%0h exp=%0h", i, bus.mem_a_o, e); else passed++;
      tick();
    end
    bus.q_pop_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      e = ASZ'(17'h1FFFE) + ASZ'(i);
      sample();
      total++; if (bus.q_vld_o !== 1'b1) $display("FAIL wrap_vld[%0d] got=%0h exp=1", i, bus.q_vld_o); else passed++;
      total++; if (bus.q_p_o !== e) $display("FAIL wrap_qp[%0d] got=%0h exp=%0h", i, bus.q_p_o, e); else passed++;
      total++; if (bus.q_d_o !== mdat(e)) $display("FAIL wrap_qd[%0d] got=%0h exp=%0h", i, bus.q_d_o, mdat(e)); else passed++;
      tick();
    end
    bus.q_pop_i = 1'b0;
  endtask

  task automatic test_pop_edge();
    bus.br_psel_i = 1'b1;
    bus.br_p_i    = ASZ'(17'h00ABC);
    sample();
    tick();
    bus.br_psel_i = 1'b0;
    bus.q_pop_i   = 1'b1;
    sample();
    total++; if (bus.cnt_o !== '0) $display("FAIL empty_pop_cnt1 got=%0h exp=0", bus.cnt_o); else passed++;
    tick(); sample();
    total++; if (bus.cnt_o !== '0) $display("FAIL empty_pop_cnt2 got=%0h exp=0", bus.cnt_o); else passed++;
    tick();
    bus.q_pop_i = 1'b0;
    sample();
    total++; if (bus.cnt_o !== CSZ'(1)) $display("FAIL empty_pop_cnt3 got=%0h exp=1", bus.cnt_o); else passed++;
    total++; if (bus.q_p_o !== ASZ'(17'h00ABC)) $display("FAIL empty_pop_head got=%0h exp=abc", bus.q_p_o); else passed++;
    tick();
    bus.q_pop_i = 1'b1;
    sample();
    total++; if (bus.cnt_o !== CSZ'(2)) $display("FAIL pushpop_before got=%0h exp=2", bus.cnt_o); else passed++;
    tick();
    bus.q_pop_i = 1'b0;
    sample();
    total++; if (bus.cnt_o !== CSZ'(2)) $display("FAIL pushpop_cnt got=%0h exp=2", bus.cnt_o); else passed++;
    total++; if (bus.q_p_o !== ASZ'(17'h00ABD)) $display("FAIL pushpop_head got=%0h exp=abd", bus.q_p_o); else passed++;
  endtask

  task automatic test_async_reset();
    tick();
    bus.q_pop_i = 1'b1;
    repeat (3) tick();
    #2;
    rst = 1'b1;
    #1;
    total++; if (bus.mem_req_o !== 1'b0) $display("FAIL arst_req got=%0h exp=0", bus.mem_req_o); else passed++;
    total++; if (bus.q_vld_o !== 1'b0) $display("FAIL arst_vld got=%0h exp=0", bus.q_vld_o); else passed++;
    total++; if (bus.cnt_o !== '0) $display("FAIL arst_cnt got=%0h exp=0", bus.cnt_o); else passed++;
    tick();
    rst = 1'b0;
    bus.q_pop_i = 1'b0;
    sample();
    total++; if (bus.mem_req_o !== 1'b1) $display("FAIL arst_restart_req got=%0h exp=1", bus.mem_req_o); else passed++;
    total++; if (bus.mem_a_o !== '0) $display("FAIL arst_restart_a got=%0h exp=0", bus.mem_a_o); else passed++;
    tick(); tick(); sample();
    total++; if (bus.q_vld_o !== 1'b1) $display("FAIL arst_head_vld got=%0h exp=1", bus.q_vld_o); else passed++;
    total++; if (bus.q_p_o !== '0) $display("FAIL arst_head_qp got=%0h exp=0", bus.q_p_o); else passed++;
    total++; if (bus.q_d_o !== 8'h10) $display("FAIL arst_head_qd got=%0h exp=10", bus.q_d_o); else passed++;
  endtask

  // Random pops and redirects; the consumer must see target, target+1, ...
  // after every redirect, with the matching memory byte each time.
  task automatic test_random();
    logic [ASZ-1:0] exp_a;
    int             idle;
    logic           redir;
    logic           pop;
    exp_a = '0;
    idle  = 0;
    for (int c = 0; c < 2000; c++) begin
      tick();
      redir = (c == 0) || ($urandom_range(0, 39) == 0);
      pop   = 1'($urandom_range(0, 1));
      bus.br_psel_i = redir;
      bus.br_p_i    = ASZ'($urandom());
      bus.q_pop_i   = pop;
      sample();
      total++; if (bus.cnt_o > CSZ'(DEPTH)) $display("FAIL rnd_cnt_max c=%0d got=%0d exp<=%0d", c, bus.cnt_o, DEPTH); else passed++;
      total++; if (bus.q_vld_o !== (bus.cnt_o != '0)) $display("FAIL rnd_vld c=%0d got=%0h exp=%0h", c, bus.q_vld_o, bus.cnt_o != '0); else passed++;
      if (redir) begin
        total++; if (bus.mem_req_o !== 1'b0) $display("FAIL rnd_redir_req c=%0d got=%0h exp=0", c, bus.mem_req_o); else passed++;
        exp_a = bus.br_p_i;
        idle  = 0;
      end else begin
        if (pop && bus.q_vld_o === 1'b1) begin
          total++; if (bus.q_p_o !== exp_a) $display("FAIL rnd_qp c=%0d got=%0h exp=%0h", c, bus.q_p_o, exp_a); else passed++;
          total++; if (bus.q_d_o !== mdat(exp_a)) $display("FAIL rnd_qd c=%0d got=%0h exp=%0h", c, bus.q_d_o, mdat(exp_a)); else passed++;
          exp_a = exp_a + ASZ'(1);
        end
        idle = (bus.q_vld_o === 1'b1) ? 0 : idle + 1;
        total++; if (idle > 2) $display("FAIL rnd_starve c=%0d got=%0d idle cycles exp<=2", c, idle); else passed++;
      end
    end
    bus.br_psel_i = 1'b0;
    bus.q_pop_i   = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_fill();
    test_stream();
    test_redirect();
    test_wrap();
    test_pop_edge();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
